// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its Kogge-Stone slice.
package nibble_serial_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble build still keeps a 1-bit index.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between a requester (master) and the serial adder (slave).
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    import nibble_serial_adder_pkg::*;

    localparam int WIDTH = SLICE_W * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/nibble_serial_adder_ksa_slice.sv
// 4-bit Kogge-Stone adder; carry-in is folded into the bit-0 generate term so the
// prefix tree alone produces every internal carry.
module ksa_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_g1;
    logic [SLICE_W-1:2] w_p1;
    logic [SLICE_W-1:0] w_g2;
    logic [SLICE_W-1:0] w_c;

    assign w_p = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE_W; gi++) begin : g_bit
            if (gi == 0) begin : g_gen0
                assign w_g[gi] = (a[gi] & b[gi]) | (w_p[gi] & cin);
            end else begin : g_genn
                assign w_g[gi] = a[gi] & b[gi];
            end

            // Prefix level 1, span 1
            if (gi == 0) begin : g_l1_pass
                assign w_g1[gi] = w_g[gi];
            end else begin : g_l1
                assign w_g1[gi] = w_g[gi] | (w_p[gi] & w_g[gi-1]);
            end
            if (gi >= 2) begin : g_l1_p
                assign w_p1[gi] = w_p[gi] & w_p[gi-1];
            end

            // Prefix level 2, span 2
            if (gi < 2) begin : g_l2_pass
                assign w_g2[gi] = w_g1[gi];
            end else begin : g_l2
                assign w_g2[gi] = w_g1[gi] | (w_p1[gi] & w_g1[gi-2]);
            end

            if (gi == 0) begin : g_c0
                assign w_c[gi] = cin;
            end else begin : g_cn
                assign w_c[gi] = w_g2[gi-1];
            end
        end
    endgenerate

    assign sum  = w_p ^ w_c;
    assign cout = w_g2[SLICE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder: one shared 4-bit Kogge-Stone slice processes one nibble per clock,
// LSB first, behind a valid/ready handshake on both operand and result sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int                WIDTH    = SLICE_W * NIBBLES;
    localparam int                IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [SLICE_W-1:0] w_a_nibs [NIBBLES];
    logic [SLICE_W-1:0] w_b_nibs [NIBBLES];
    logic [SLICE_W-1:0] w_a_nib;
    logic [SLICE_W-1:0] w_b_nib;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic               w_last;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_a_nibs[gi] = r_a[gi*SLICE_W +: SLICE_W];
            assign w_b_nibs[gi] = r_b[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign w_a_nib = w_a_nibs[r_idx];
    assign w_b_nib = w_b_nibs[r_idx];
    assign w_last  = (r_idx == LAST_IDX);

    ksa_slice u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_next = ST_ADD;
            ST_ADD:  if (w_last)        w_state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_DONE);
    end

    // Index freezes on the last nibble so it never wraps while in ADD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*SLICE_W +: SLICE_W] <= w_slice_sum;
                        end
                    end
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        r_cout <= w_slice_cout;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
